pipe_stage_fwd: RTL and testbench

Parametrised pipeline stage register that carries an opaque per-instruction payload plus two register-file operands through a valid/ready handshake. It has optional skid buffering that breaks the combinational ready path, a synchronous flush, and N-source operand forwarding. Forwarded values are captured into held entries, so a stalled instruction keeps correct operands after the producer retires. It sits between decode and execute (or between any two pipe stages) in the in-order core.

---
 rtl/pipe_stage_fwd.sv | 199 +++++++++++++++++++
 tb/tb_pipe_stage_fwd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fwd.sv
// pipe_stage_fwd: valid/ready pipeline stage carrying a payload and two
// register-file operands. It has an optional two-entry skid buffer, a
// synchronous flush, and N-source operand forwarding. Forwarded values are
// captured into held entries, so a stalled instruction keeps correct operands.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_i                       kill all held entries
//   in_valid_i / in_ready_o       upstream handshake
//   in_payload_i                  opaque payload (PW bits)
//   in_rs{1,2}_idx_i / _data_i    source indices and register-file data
//   out_valid_o / out_ready_i     downstream handshake
//   out_payload_o, out_rs*_o      main entry contents (zero when !out_valid_o)
//   fwd_wen_i/fwd_idx_i/fwd_data_i  NFWD forwarding sources, index 0 wins
module pipe_stage_fwd #(
  parameter int unsigned PW   = 64,
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2,
  parameter int unsigned SKID = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PW-1:0]        in_payload_i,
  input  logic [4:0]           in_rs1_idx_i,
  input  logic [4:0]           in_rs2_idx_i,
  input  logic [XLEN-1:0]      in_rs1_data_i,
  input  logic [XLEN-1:0]      in_rs2_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PW-1:0]        out_payload_o,
  output logic [4:0]           out_rs1_idx_o,
  output logic [4:0]           out_rs2_idx_o,
  output logic [XLEN-1:0]      out_rs1_data_o,
  output logic [XLEN-1:0]      out_rs2_data_o,
  input  logic [NFWD-1:0]      fwd_wen_i,
  input  logic [5*NFWD-1:0]    fwd_idx_i,
  input  logic [XLEN*NFWD-1:0] fwd_data_i
);

  localparam int unsigned IW = 5;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  state_e state_q, state_d;

  logic [PW-1:0]   main_payload, skid_payload;
  logic [IW-1:0]   main_rs1_idx, main_rs2_idx, skid_rs1_idx, skid_rs2_idx;
  logic [XLEN-1:0] main_rs1, main_rs2, skid_rs1, skid_rs2;

  logic main_valid, skid_valid;
  logic in_fire, out_fire;
  logic load_main_in, load_skid_in, move_skid;

  logic [XLEN-1:0] in_rs1_fwd, in_rs2_fwd;
  logic [XLEN-1:0] main_rs1_fwd, main_rs2_fwd;
  logic [XLEN-1:0] skid_rs1_fwd, skid_rs2_fwd;

  // Priority forward match: iterate high-to-low so the lowest hitting k wins; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_resolve(
    input logic [IW-1:0]        idx,
    input logic [XLEN-1:0]      data,
    input logic [NFWD-1:0]      wen,
    input logic [IW*NFWD-1:0]   fidx,
    input logic [XLEN*NFWD-1:0] fdata
  );
    logic [XLEN-1:0] res;
    res = data;
    for (int k = int'(NFWD) - 1; k >= 0; k--) begin
      if (wen[k] && (idx != '0) && (idx == fidx[IW*k +: IW])) begin
        res = fdata[XLEN*k +: XLEN];
      end
    end
    return res;
  endfunction

  // Forward-resolved operands for the input and both held entries.
  always_comb begin
    in_rs1_fwd   = fwd_resolve(in_rs1_idx_i, in_rs1_data_i, fwd_wen_i, fwd_idx_i, fwd_data_i);
    in_rs2_fwd   = fwd_resolve(in_rs2_idx_i, in_rs2_data_i, fwd_wen_i, fwd_idx_i, fwd_data_i);
    main_rs1_fwd = fwd_resolve(main_rs1_idx, main_rs1, fwd_wen_i, fwd_idx_i, fwd_data_i);
    main_rs2_fwd = fwd_resolve(main_rs2_idx, main_rs2, fwd_wen_i, fwd_idx_i, fwd_data_i);
    skid_rs1_fwd = fwd_resolve(skid_rs1_idx, skid_rs1, fwd_wen_i, fwd_idx_i, fwd_data_i);
    skid_rs2_fwd = fwd_resolve(skid_rs2_idx, skid_rs2, fwd_wen_i, fwd_idx_i, fwd_data_i);
  end

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // With a skid, ready depends only on registered occupancy; without, it looks through to out_ready_i.
  assign in_ready_o = ((SKID != 0) ? !skid_valid : (!main_valid || out_ready_i)) && !rst;

  assign out_valid_o = main_valid && !flush_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  assign out_payload_o  = out_valid_o ? main_payload : '0;
  assign out_rs1_idx_o  = out_valid_o ? main_rs1_idx : '0;
  assign out_rs2_idx_o  = out_valid_o ? main_rs2_idx : '0;
  assign out_rs1_data_o = out_valid_o ? main_rs1_fwd : '0;
  assign out_rs2_data_o = out_valid_o ? main_rs2_fwd : '0;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state and entry load controls; flush wins over any fire.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          if (SKID != 0) begin
            load_skid_in = 1'b1;
            state_d      = ST_FULL;
          end
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          move_skid = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d      = ST_EMPTY;
      load_main_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
    end
  end

  // Entry storage: load, skid-to-main move, or in-place forward capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_payload <= '0;
      main_rs1_idx <= '0;
      main_rs2_idx <= '0;
      main_rs1     <= '0;
      main_rs2     <= '0;
      skid_payload <= '0;
      skid_rs1_idx <= '0;
      skid_rs2_idx <= '0;
      skid_rs1     <= '0;
      skid_rs2     <= '0;
    end else begin
      if (load_main_in) begin
        main_payload <= in_payload_i;
        main_rs1_idx <= in_rs1_idx_i;
        main_rs2_idx <= in_rs2_idx_i;
        main_rs1     <= in_rs1_fwd;
        main_rs2     <= in_rs2_fwd;
      end else if (move_skid) begin
        main_payload <= skid_payload;
        main_rs1_idx <= skid_rs1_idx;
        main_rs2_idx <= skid_rs2_idx;
        main_rs1     <= skid_rs1_fwd;
        main_rs2     <= skid_rs2_fwd;
      end else if (main_valid) begin
        main_rs1 <= main_rs1_fwd;
        main_rs2 <= main_rs2_fwd;
      end

      if (load_skid_in) begin
        skid_payload <= in_payload_i;
        skid_rs1_idx <= in_rs1_idx_i;
        skid_rs2_idx <= in_rs2_idx_i;
        skid_rs1     <= in_rs1_fwd;
        skid_rs2     <= in_rs2_fwd;
      end else if (skid_valid) begin
        skid_rs1 <= skid_rs1_fwd;
        skid_rs2 <= skid_rs2_fwd;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_fwd.sv
// Directed bench for pipe_stage_fwd: one SKID=1 instance and one SKID=0
// instance sharing most inputs; each has its own in_valid/out_ready.
module tb_pipe_stage_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_valid0;
  logic        out_ready, out_ready0;
  logic [63:0] payload;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_data, rs2_data;
  logic [1:0]  fwd_wen;
  logic [9:0]  fwd_idx;
  logic [63:0] fwd_data;

  logic        in_ready, out_valid;
  logic [63:0] out_payload;
  logic [4:0]  out_rs1_idx, out_rs2_idx;
  logic [31:0] out_rs1, out_rs2;

  logic        in_ready0, out_valid0;
  logic [63:0] out_payload0;
  logic [4:0]  out_rs1_idx0, out_rs2_idx0;
  logic [31:0] out_rs1_0, out_rs2_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_fwd #(.PW(64), .XLEN(32), .NFWD(2), .SKID(1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_payload_i(payload),
    .in_rs1_idx_i(rs1_idx), .in_rs2_idx_i(rs2_idx),
    .in_rs1_data_i(rs1_data), .in_rs2_data_i(rs2_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
    .out_rs1_idx_o(out_rs1_idx), .out_rs2_idx_o(out_rs2_idx),
    .out_rs1_data_o(out_rs1), .out_rs2_data_o(out_rs2),
    .fwd_wen_i(fwd_wen), .fwd_idx_i(fwd_idx), .fwd_data_i(fwd_data)
  );

  pipe_stage_fwd #(.PW(64), .XLEN(32), .NFWD(2), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_payload_i(payload),
    .in_rs1_idx_i(rs1_idx), .in_rs2_idx_i(rs2_idx),
    .in_rs1_data_i(rs1_data), .in_rs2_data_i(rs2_data),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_payload_o(out_payload0),
    .out_rs1_idx_o(out_rs1_idx0), .out_rs2_idx_o(out_rs2_idx0),
    .out_rs1_data_o(out_rs1_0), .out_rs2_data_o(out_rs2_0),
    .fwd_wen_i(fwd_wen), .fwd_idx_i(fwd_idx), .fwd_data_i(fwd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_valid0 = 1'b0;
    out_ready = 1'b1; out_ready0 = 1'b0;
    payload = '0; rs1_idx = '0; rs2_idx = '0; rs1_data = '0; rs2_data = '0;
    fwd_wen = '0; fwd_idx = '0; fwd_data = '0;

    // Reset state
    tick(); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_payload", out_payload, 64'd0);
    chk("rst_rs1", 64'(out_rs1), 64'd0);
    chk("rst_in_ready0", 64'(in_ready0), 64'd0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Streaming 1..8 back-to-back, out_ready high
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        in_valid = 1'b1; payload = 64'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 1) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_payload", out_payload, 64'(i - 1));
      end else begin
        chk("stream_first_empty", 64'(out_valid), 64'd0);
      end
      tick();
    end
    #1;
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_drained_pl", out_payload, 64'd0);

    // Stall: three offers with out_ready low, only two accepted
    out_ready = 1'b0; in_valid = 1'b1; payload = 64'h11; #1;
    chk("stall_a_ready", 64'(in_ready), 64'd1);
    tick();
    payload = 64'h12; #1;
    chk("stall_b_ready", 64'(in_ready), 64'd1);
    chk("stall_b_payload", out_payload, 64'h11);
    tick();
    payload = 64'h13; #1;
    chk("stall_c_ready", 64'(in_ready), 64'd0);
    chk("stall_c_payload", out_payload, 64'h11);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("drain_d_valid", 64'(out_valid), 64'd1);
    chk("drain_d_payload", out_payload, 64'h11);
    chk("drain_d_ready", 64'(in_ready), 64'd0);
    tick(); #1;
    chk("drain_e_payload", out_payload, 64'h12);
    chk("drain_e_ready", 64'(in_ready), 64'd1);
    tick(); #1;
    chk("drain_f_valid", 64'(out_valid), 64'd0);
    chk("drain_f_ready", 64'(in_ready), 64'd1);

    // Capture: stale rs1=5 entry, one-cycle forward from source 1
    out_ready = 1'b0; in_valid = 1'b1; payload = 64'h21;
    rs1_idx = 5'd5; rs1_data = 32'h0; rs2_idx = 5'd7; rs2_data = 32'h70;
    tick();
    in_valid = 1'b0; rs1_data = 32'hFFFF; rs2_data = 32'hFFFF; #1;
    chk("cap_stale", 64'(out_rs1), 64'h0);
    chk("cap_idx", 64'(out_rs1_idx), 64'd5);
    fwd_wen = 2'b10; fwd_idx = {5'd5, 5'd0}; fwd_data = {32'hDEAD, 32'h0}; #1;
    chk("cap_comb", 64'(out_rs1), 64'hDEAD);
    chk("cap_rs2_untouched", 64'(out_rs2), 64'h70);
    tick();
    fwd_wen = 2'b00; #1;
    chk("cap_held", 64'(out_rs1), 64'hDEAD);

    // Priority: both sources hit rs2=7, source 0 wins and is captured
    fwd_wen = 2'b11; fwd_idx = {5'd7, 5'd7}; fwd_data = {32'hB, 32'hA}; #1;
    chk("prio_comb", 64'(out_rs2), 64'hA);
    chk("prio_rs1", 64'(out_rs1), 64'hDEAD);
    tick();
    fwd_wen = 2'b00; #1;
    chk("prio_held", 64'(out_rs2), 64'hA);
    out_ready = 1'b1;
    tick();

    // x0 entry, with the input rs2 forward-resolved before storage
    out_ready = 1'b0; in_valid = 1'b1; payload = 64'h31;
    rs1_idx = 5'd0; rs1_data = 32'h1234; rs2_idx = 5'd9; rs2_data = 32'h99;
    fwd_wen = 2'b10; fwd_idx = {5'd9, 5'd0}; fwd_data = {32'h9999, 32'h0}; #1;
    chk("x0_prev_drained", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    fwd_wen = 2'b01; fwd_idx = {5'd0, 5'd0}; fwd_data = {32'h0, 32'h5555}; #1;
    chk("x0_no_fwd", 64'(out_rs1), 64'h1234);
    chk("in_fwd_stored", 64'(out_rs2), 64'h9999);

    // Flush with FULL occupancy and same-cycle in/out handshakes
    fwd_wen = 2'b00; in_valid = 1'b1; payload = 64'h32; #1;
    chk("flush_pre_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b1; in_valid = 1'b1; payload = 64'h33; out_ready = 1'b1; #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_payload", out_payload, 64'd0);
    chk("flush_rs1", 64'(out_rs1), 64'd0);
    chk("flush_full_ready", 64'(in_ready), 64'd0);
    tick();
    payload = 64'h34; #1;
    chk("flush_ready_unmasked", 64'(in_ready), 64'd1);
    chk("flush_empty_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_payload", out_payload, 64'd0);
    chk("post_flush_ready", 64'(in_ready), 64'd1);

    // Reset mid-operation drops the held entry
    in_valid = 1'b1; payload = 64'h51;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("mid_loaded", out_payload, 64'h51);
    rst = 1'b1; #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0; #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_payload", out_payload, 64'd0);
    chk("mid_rst_ready_after", 64'(in_ready), 64'd1);

    // SKID=0: ready follows out_ready combinationally when main is full
    in_valid0 = 1'b1; out_ready0 = 1'b0; payload = 64'h41; #1;
    chk("s0_empty_ready", 64'(in_ready0), 64'd1);
    tick();
    in_valid0 = 1'b0; #1;
    chk("s0_valid", 64'(out_valid0), 64'd1);
    chk("s0_payload", out_payload0, 64'h41);
    chk("s0_stall_ready", 64'(in_ready0), 64'd0);
    out_ready0 = 1'b1; #1;
    chk("s0_release_ready", 64'(in_ready0), 64'd1);
    tick(); #1;
    chk("s0_drained", 64'(out_valid0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
